instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0, SHALL be the PC loaded on reset.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  reset is synchronous and active-high.
REQ-004 imem_req  out  1  instruction memory request, held until accepted.
REQ-005 imem_addr  out  `WORD  byte address of the request, which equals the current PC.
REQ-006 imem_ready  in  1  the memory accepts the request in any cycle where imem_req and imem_ready are both high.
REQ-007 imem_rvalid  in  1  response strobe, one cycle wide.
REQ-008 imem_rdata  in  `INSTR_LEN  response instruction word.
REQ-009 instruction  out  `INSTR_LEN  registered instruction presented to Decode.
REQ-010 pc_out  out  `WORD  PC of the presented instruction.
REQ-011 instr_valid  out  1  instruction and pc_out are valid.
REQ-012 instr_ack  in  1  consumer has taken the instruction.
REQ-013 resolve_valid  in  1  branch decision for the held instruction is present this cycle.
REQ-014 branch, branch_if_zero, branch_if_not_zero, zero  in  1 each  branch controls and ALU zero flag.
REQ-015 branch_offset  in  `WORD  sign-extended offset in words.
REQ-016 fetch_count, stall_count  out  32 each  performance counters (see Configuration).

Function
REQ-017 The FSM SHALL have the states REQ, WAIT, HOLD and RESOLVE.
REQ-018 REQ: imem_req=1; the FSM SHALL move to WAIT on imem_ready=1, otherwise stay in REQ.
REQ-019 WAIT: on imem_rvalid the FSM SHALL capture imem_rdata into instruction and PC into pc_out, then go to HOLD. The earliest response is one cycle after acceptance.
REQ-020 HOLD: instr_valid=1 and instruction/pc_out stable; on instr_ack the FSM SHALL go to RESOLVE.
REQ-021 RESOLVE: on resolve_valid the FSM SHALL load next PC and go to REQ in the following cycle.
REQ-022 taken = branch | (branch_if_zero & zero) | (branch_if_not_zero & ~zero).
REQ-023 Next PC = taken ? PC + (branch_offset << 2) : PC + 4. All arithmetic is modulo 2^64, and wrap-around SHALL NOT be flagged.
REQ-024 The FSM SHALL ignore imem_rvalid outside WAIT, instr_ack outside HOLD, and resolve_valid outside RESOLVE.
REQ-025 The minimum loop is accept at cycle n, rvalid at n+1, instr_valid at n+2, ack at n+2, resolve at n+3, imem_req at n+4.
REQ-026 instr_ack may arrive in the first cycle of instr_valid.
REQ-027 instr_valid and imem_req SHALL never be high in the same cycle.
REQ-028 imem_addr SHALL be stable while imem_req is high.

Reset
REQ-029 When reset is high the block SHALL set state=REQ, PC=RESET_PC, instruction=0, pc_out=0, instr_valid=0 and both counters to 0; reset overrides all other inputs.
REQ-030 Reset during WAIT SHALL cause a response arriving after reset to be ignored, because it arrives while the FSM is in REQ.
REQ-031 imem_req SHALL be high in the first cycle after reset is released.

Configuration
REQ-032 With FETCH_PERF_COUNTERS_EN defined: fetch_count SHALL increment on each instr_ack taken in HOLD, and stall_count SHALL increment each cycle spent in REQ or WAIT; both SHALL saturate at 32'hFFFFFFFF.
REQ-033 Without FETCH_PERF_COUNTERS_EN: both counter ports SHALL remain present and tied to 0, with no counter flops.

Structure
REQ-034 The FSM state encodings and the PC increment constant (4) SHALL live in constants.vh; `WORD and `INSTR_LEN SHALL be reused from there.
REQ-035 The combinational next-PC logic (REQ-022, REQ-023) SHALL be the single sub-module next_pc_calc.

Verification
REQ-036 Reset, then imem_ready=1 and rvalid next cycle with rdata=32'h8B020020 -> instr_valid at cycle 2 with instruction=8B020020 and pc_out=0; after ack and resolve with no branch, imem_addr=4.
REQ-037 At PC=0x10, resolve with branch=1 and branch_offset=-2 -> next imem_addr=0x08; with branch_if_zero=1, zero=0 -> 0x14.
REQ-038 At PC=0xFFFF_FFFF_FFFF_FFFC with no branch -> next imem_addr=0x0.
REQ-039 Hold imem_ready=0 for 5 cycles -> imem_addr is stable and stall_count increases by 5 (macro on) or stays 0 (macro off).
REQ-040 Assert reset during WAIT, then rvalid the cycle after reset -> the response is ignored, instr_valid=0 and imem_req=1 with imem_addr=RESET_PC.
REQ-041 Hold instr_ack=0 for 10 cycles in HOLD -> instr_valid, instruction and pc_out are held; spurious resolve_valid pulses have no effect.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: widths, PC step and FSM state type for the fetch stage.
`include "constants.vh"
package instruction_fetch_pkg;
    localparam int XLEN = `WORD;
    localparam int ILEN = `INSTR_LEN;
    localparam logic [XLEN-1:0] PC_INC = `PC_INC;
    typedef enum logic [1:0] {
        S_REQ     = `FETCH_S_REQ,
        S_WAIT    = `FETCH_S_WAIT,
        S_HOLD    = `FETCH_S_HOLD,
        S_RESOLVE = `FETCH_S_RESOLVE
    } fetch_state_t;
endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: instruction memory, decode and branch-resolve signals of the fetch stage.
interface instruction_fetch_if;
    import instruction_fetch_pkg::*;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [ILEN-1:0] imem_rdata;
    logic [ILEN-1:0] instruction;
    logic [XLEN-1:0] pc_out;
    logic            instr_valid;
    logic            instr_ack;
    logic            resolve_valid;
    logic            branch;
    logic            branch_if_zero;
    logic            branch_if_not_zero;
    logic            zero;
    logic [XLEN-1:0] branch_offset;
    modport master (
        output imem_req, imem_addr, instruction, pc_out, instr_valid,
        input  imem_ready, imem_rvalid, imem_rdata, instr_ack, resolve_valid,
               branch, branch_if_zero, branch_if_not_zero, zero, branch_offset
    );
    modport slave (
        input  imem_req, imem_addr, instruction, pc_out, instr_valid,
        output imem_ready, imem_rvalid, imem_rdata, instr_ack, resolve_valid,
               branch, branch_if_zero, branch_if_not_zero, zero, branch_offset
    );
endinterface

// File: rtl/constants.vh
// constants.vh: shared widths, fetch FSM state encodings and the sequential PC step.
`ifndef CONSTANTS_VH
`define CONSTANTS_VH
`define WORD 64
`define INSTR_LEN 32
`define FETCH_S_REQ 2'd0
`define FETCH_S_WAIT 2'd1
`define FETCH_S_HOLD 2'd2
`define FETCH_S_RESOLVE 2'd3
`define PC_INC 64'd4
`endif

// File: rtl/instruction_fetch_next_pc_calc.sv
// next_pc_calc: branch decision and next PC; offsets are in words and all sums wrap modulo 2^64.
module next_pc_calc
    import instruction_fetch_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic            branch,
    input  logic            branch_if_zero,
    input  logic            branch_if_not_zero,
    input  logic            zero,
    input  logic [XLEN-1:0] branch_offset,
    output logic [XLEN-1:0] next_pc
);
    logic taken;
    assign taken = branch | (branch_if_zero & zero) | (branch_if_not_zero & ~zero);
    assign next_pc = taken ? pc + (branch_offset << 2) : pc + PC_INC;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: single-outstanding fetch FSM (REQ/WAIT/HOLD/RESOLVE).
// Define FETCH_PERF_COUNTERS_EN to build the saturating fetch/stall counters; otherwise they read 0.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
    input  logic                clk,
    input  logic                reset,
    instruction_fetch_if.master bus,
    output logic [31:0]         fetch_count,
    output logic [31:0]         stall_count
);
    fetch_state_t    state, state_n;
    logic [XLEN-1:0] pc, next_pc;
    logic [ILEN-1:0] instr_q;
    logic [XLEN-1:0] pc_out_q;

    next_pc_calc u_next_pc (
        .pc                 (pc),
        .branch             (bus.branch),
        .branch_if_zero     (bus.branch_if_zero),
        .branch_if_not_zero (bus.branch_if_not_zero),
        .zero               (bus.zero),
        .branch_offset      (bus.branch_offset),
        .next_pc            (next_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            instr_q  <= '0;
            pc_out_q <= '0;
        end else begin
            state <= state_n;
            if (state == S_WAIT && bus.imem_rvalid) begin
                instr_q  <= bus.imem_rdata;
                pc_out_q <= pc;
            end
            if (state == S_RESOLVE && bus.resolve_valid) pc <= next_pc;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_REQ:     state_n = bus.imem_ready    ? S_WAIT    : S_REQ;
            S_WAIT:    state_n = bus.imem_rvalid   ? S_HOLD    : S_WAIT;
            S_HOLD:    state_n = bus.instr_ack     ? S_RESOLVE : S_HOLD;
            S_RESOLVE: state_n = bus.resolve_valid ? S_REQ     : S_RESOLVE;
            default:   state_n = S_REQ;
        endcase
    end

    // Outputs decode straight from the state register, so req and valid are mutually exclusive.
    assign bus.imem_req    = state == S_REQ;
    assign bus.imem_addr   = pc;
    assign bus.instr_valid = state == S_HOLD;
    assign bus.instruction = instr_q;
    assign bus.pc_out      = pc_out_q;

`ifdef FETCH_PERF_COUNTERS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (state == S_HOLD && bus.instr_ack && ~&fetch_count) fetch_count <= fetch_count + 32'd1;
            if ((state == S_REQ || state == S_WAIT) && ~&stall_count) stall_count <= stall_count + 32'd1;
        end
    end
`else
    assign fetch_count = '0;
    assign stall_count = '0;
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed vector table of full fetch/resolve loops plus stall, hold and reset-in-WAIT sequences.
module tb_instruction_fetch;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fetch_count, stall_count;
    int          n_vec = 0;
    int          n_err = 0;
    int          n_txn = 0;

    instruction_fetch_if bus ();

    instruction_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .fetch_count (fetch_count),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] rdata;
        logic        br, biz, binz, z;
        logic [63:0] off;
        logic [63:0] npc;
    } vec_t;

    vec_t tbl [9];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs;
        bus.imem_ready = 0; bus.imem_rvalid = 0; bus.imem_rdata = '0;
        bus.instr_ack = 0; bus.resolve_valid = 0; bus.branch = 0;
        bus.branch_if_zero = 0; bus.branch_if_not_zero = 0; bus.zero = 0;
        bus.branch_offset = '0;
    endtask

    task automatic run_txn(input vec_t v);
        chk("req_before_accept", {63'd0, bus.imem_req}, 64'd1);
        chk("addr_before_accept", bus.imem_addr, v.pc);
        bus.imem_ready = 1;
        tick;
        bus.imem_ready = 0;
        chk("req_in_wait", {63'd0, bus.imem_req}, 64'd0);
        chk("valid_in_wait", {63'd0, bus.instr_valid}, 64'd0);
        bus.imem_rvalid = 1; bus.imem_rdata = v.rdata;
        tick;
        bus.imem_rvalid = 0; bus.imem_rdata = '0;
        chk("valid_in_hold", {63'd0, bus.instr_valid}, 64'd1);
        chk("req_in_hold", {63'd0, bus.imem_req}, 64'd0);
        chk("instruction", {32'd0, bus.instruction}, {32'd0, v.rdata});
        chk("pc_out", bus.pc_out, v.pc);
        bus.instr_ack = 1;
        tick;
        bus.instr_ack = 0;
        chk("valid_in_resolve", {63'd0, bus.instr_valid}, 64'd0);
        bus.resolve_valid = 1; bus.branch = v.br; bus.branch_if_zero = v.biz;
        bus.branch_if_not_zero = v.binz; bus.zero = v.z; bus.branch_offset = v.off;
        tick;
        clear_inputs();
        chk("req_after_resolve", {63'd0, bus.imem_req}, 64'd1);
        chk("next_addr", bus.imem_addr, v.npc);
        n_txn++;
    endtask

    initial begin
        tbl[0] = '{64'h0,                 32'h8B020020, 0, 0, 0, 0, 64'd0,  64'h4};
        tbl[1] = '{64'h4,                 32'h11111111, 1, 0, 0, 0, 64'd3,  64'h10};
        tbl[2] = '{64'h10,                32'h22222222, 1, 0, 0, 0, -64'd2, 64'h8};
        tbl[3] = '{64'h8,                 32'h33333333, 0, 0, 1, 0, 64'd2,  64'h10};
        tbl[4] = '{64'h10,                32'h44444444, 0, 1, 0, 0, 64'd5,  64'h14};
        tbl[5] = '{64'h14,                32'h55555555, 0, 1, 0, 1, -64'd6, 64'hFFFF_FFFF_FFFF_FFFC};
        tbl[6] = '{64'hFFFF_FFFF_FFFF_FFFC, 32'h66666666, 0, 0, 0, 0, 64'd9, 64'h0};
        tbl[7] = '{64'h0,                 32'h77777777, 0, 0, 1, 1, 64'd7,  64'h4};
        tbl[8] = '{64'h4,                 32'h88888888, 1, 0, 0, 1, 64'd0,  64'h4};

        clear_inputs();
        reset = 1;
        repeat (3) tick;
        chk("rst_valid", {63'd0, bus.instr_valid}, 64'd0);
        chk("rst_instruction", {32'd0, bus.instruction}, 64'd0);
        chk("rst_pc_out", bus.pc_out, 64'd0);
        chk("rst_req", {63'd0, bus.imem_req}, 64'd1);
        chk("rst_addr", bus.imem_addr, 64'd0);
        chk("rst_fetch_count", {32'd0, fetch_count}, 64'd0);
        chk("rst_stall_count", {32'd0, stall_count}, 64'd0);
        reset = 0;

        // Memory not ready for 5 cycles: address held, stall counter advances.
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("stall_req", {63'd0, bus.imem_req}, 64'd1);
            chk("stall_addr", bus.imem_addr, 64'd0);
        end
`ifdef FETCH_PERF_COUNTERS_EN
        chk("stall_count", {32'd0, stall_count}, 64'd5);
`else
        chk("stall_count", {32'd0, stall_count}, 64'd0);
`endif

        foreach (tbl[i]) run_txn(tbl[i]);

        // Consumer stalls 10 cycles in HOLD while resolve and rvalid pulse spuriously.
        chk("hold_seq_addr", bus.imem_addr, 64'h4);
        bus.imem_ready = 1;
        tick;
        bus.imem_ready = 0;
        bus.imem_rvalid = 1; bus.imem_rdata = 32'hDEADBEEF;
        tick;
        for (int i = 0; i < 10; i++) begin
            bus.imem_rvalid = i[0]; bus.imem_rdata = 32'hBAD0_0000 | i;
            bus.resolve_valid = ~i[0]; bus.branch = 1; bus.branch_offset = -64'd1;
            tick;
            chk("hold_valid", {63'd0, bus.instr_valid}, 64'd1);
            chk("hold_instruction", {32'd0, bus.instruction}, 64'hDEADBEEF);
            chk("hold_pc_out", bus.pc_out, 64'h4);
            chk("hold_req", {63'd0, bus.imem_req}, 64'd0);
        end
        clear_inputs();
        bus.instr_ack = 1;
        tick;
        bus.instr_ack = 0;
        bus.resolve_valid = 1;
        tick;
        clear_inputs();
        n_txn++;
        chk("hold_next_addr", bus.imem_addr, 64'h8);
`ifdef FETCH_PERF_COUNTERS_EN
        chk("fetch_count", {32'd0, fetch_count}, 64'(n_txn));
`else
        chk("fetch_count", {32'd0, fetch_count}, 64'd0);
`endif

        // Reset during WAIT; the late response lands in REQ and must be dropped.
        bus.imem_ready = 1;
        tick;
        bus.imem_ready = 0;
        chk("wait_before_reset", {63'd0, bus.imem_req}, 64'd0);
        reset = 1;
        tick;
        reset = 0;
        chk("req_after_reset", {63'd0, bus.imem_req}, 64'd1);
        bus.imem_rvalid = 1; bus.imem_rdata = 32'h12345678;
        tick;
        clear_inputs();
        chk("late_rsp_valid", {63'd0, bus.instr_valid}, 64'd0);
        chk("late_rsp_instruction", {32'd0, bus.instruction}, 64'd0);
        chk("late_rsp_req", {63'd0, bus.imem_req}, 64'd1);
        chk("late_rsp_addr", bus.imem_addr, 64'd0);
        tick;
        chk("late_rsp_valid2", {63'd0, bus.instr_valid}, 64'd0);
        chk("rst_fetch_count2", {32'd0, fetch_count}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    always @(negedge clk)
        if (!reset && bus.imem_req && bus.instr_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL req_valid_overlap: got req=1 valid=1, expected not both");
        end
endmodule
